mc_mainfsm: RTL
===============

MC_MAINFSM -- requirements
Module: mc_mainfsm

Interface
REQ-001 SHALL have parameter FP_TIMEOUT, default 15, giving the maximum FPWAIT cycles before abort (range 1..255).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Op, input, 2: instruction class (00 data-proc, 01 memory, 10 branch, 11 FP).
REQ-005 SHALL have port Funct, input, 6: bit5 = immediate (I), bit0 = load (L).
REQ-006 SHALL have port FpDone, input, 1: FPU result valid.
REQ-007 SHALL have outputs IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, FpStart, FpAbort, each 1 bit.
REQ-008 SHALL have outputs ALUSrcA, ALUSrcB and ResultSrc, each 2 bits.
REQ-009 SHALL have output State, 4 bits: the current state encoding, for debug.

Function
REQ-010 SHALL be a Moore FSM; all outputs decode from the registered state only, with zero input-to-output combinational paths.
REQ-011 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, FPSTART=10, FPWAIT=11, FPWB=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-012 SHALL transition FETCH->DECODE unconditionally.
REQ-013 SHALL transition from DECODE to EXECUTER (Op=00, I=0), EXECUTEI (Op=00, I=1), MEMADR (Op=01), BRANCH (Op=10) or FPSTART (Op=11).
REQ-014 SHALL transition MEMADR->MEMREAD if L=1, else MEMADR->MEMWRITE; then MEMREAD->MEMWB->FETCH and MEMWRITE->FETCH.
REQ-015 SHALL transition EXECUTER/EXECUTEI->ALUWB->FETCH and BRANCH->FETCH.
REQ-016 SHALL transition FPSTART->FPWAIT; FPWAIT->FPWB when FpDone=1; FPWAIT->FETCH when the wait counter reaches FP_TIMEOUT with FpDone=0; FPWB->FETCH.
REQ-017 SHALL give FpDone priority when FpDone=1 in the same cycle the counter reaches FP_TIMEOUT (go to FPWB, no abort).
REQ-018 SHALL clear an 8-bit wait counter in FPSTART and increment it each FPWAIT cycle; it saturates and never wraps.
REQ-019 SHALL output in FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
REQ-020 SHALL output in DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
REQ-021 SHALL output ALUSrcA=00 and ALUSrcB=01 in MEMADR; AdrSrc=1 in MEMREAD; AdrSrc=1 and MemW=1 in MEMWRITE; ResultSrc=01 and RegW=1 in MEMWB.
REQ-022 SHALL output ALUSrcA=00 and ALUOp=1 in both EXECUTER and EXECUTEI, with ALUSrcB=00 in EXECUTER and ALUSrcB=01 in EXECUTEI.
REQ-023 SHALL output ResultSrc=00 and RegW=1 in ALUWB and in FPWB.
REQ-024 SHALL output ALUSrcA=10, ALUSrcB=01, ResultSrc=10 and Branch=1 in BRANCH.
REQ-025 SHALL output FpStart=1 only in FPSTART (exactly one cycle per FP instruction).
REQ-026 SHALL pulse FpAbort=1 for exactly one cycle, in the first FETCH following a timeout exit.
REQ-027 SHALL drive every output not listed for a state to 0 in that state.
REQ-028 SHALL ignore FpDone outside FPWAIT.

Reset
REQ-029 SHALL on reset=0 asynchronously force State=FETCH, clear the wait counter and the abort flag, independent of clk.
REQ-030 SHALL, while reset=0, hold the outputs at the FETCH values of REQ-019 with FpAbort=0, FpStart=0, RegW=0 and MemW=0.
REQ-031 SHALL, on reset asserted mid-instruction (e.g. in MEMWRITE or FPWAIT), drop MemW, RegW and FpStart within the same cycle and produce no writeback.
REQ-032 SHALL perform its first FETCH->DECODE transition on the first rising clk edge after reset deasserts.

Configuration
REQ-033 SHALL, with MC_FP_EN defined, implement FPSTART, FPWAIT and FPWB and the wait counter per REQ-016 to REQ-018.
REQ-034 SHALL, with MC_FP_EN undefined, go DECODE->FETCH for Op=11 with no writes, remove the counter, and tie FpStart and FpAbort to 0.

Verification
REQ-035 Bench SHALL check: reset pulse, then Op=00, Funct=000000 -> State 0,1,6,8,0, with RegW=1 only in the ALUWB cycle.
REQ-036 Bench SHALL check: Op=01, Funct=000001 (load) -> State 0,1,2,3,4,0, with AdrSrc=1 in MEMREAD and ResultSrc=01 with RegW=1 in MEMWB.
REQ-037 Bench SHALL check: Op=01, Funct=000000 (store) -> MemW=1 for exactly one cycle, then FETCH; Op=10 -> Branch=1 for one cycle.
REQ-038 Bench SHALL check, MC_FP_EN defined with FP_TIMEOUT=15: Op=11 with FpDone asserted on the 3rd FPWAIT cycle -> FpStart one cycle, FPWB with RegW=1, FpAbort=0.
REQ-039 Bench SHALL check: Op=11 with FpDone never asserted -> 15 FPWAIT cycles, FETCH with FpAbort=1 for one cycle, no RegW; FpDone=1 on the 15th cycle -> FPWB instead.
REQ-040 Bench SHALL check: reset=0 asserted between clk edges during MEMWRITE -> MemW drops immediately and State=0 before the next edge; with MC_FP_EN undefined, Op=11 -> State 0,1,0.

Source files
------------

// File: rtl/mc_mainfsm_if.sv
// Control bundle between the multicycle main FSM and the datapath/FPU:
// instruction fields and FpDone in, Moore control strobes and debug state out.
interface mc_mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FpDone;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       AdrSrc;
  logic       ALUOp;
  logic       FpStart;
  logic       FpAbort;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [3:0] State;

  modport slave (
    input  Op, Funct, FpDone,
    output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, FpStart, FpAbort,
    output ALUSrcA, ALUSrcB, ResultSrc, State
  );

  modport master (
    output Op, Funct, FpDone,
    input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, FpStart, FpAbort,
    input  ALUSrcA, ALUSrcB, ResultSrc, State
  );
endinterface

// File: rtl/mc_mainfsm.sv
// Moore main controller for a multicycle CPU; outputs decode from registered state only.
// Define MC_FP_EN to add the FP start/wait/writeback path with its timeout counter.
module mc_mainfsm #(
  parameter int FP_TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  mc_mainfsm_if.slave  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FPSTART  = 4'd10,
    FPWAIT   = 4'd11,
    FPWB     = 4'd12
  } state_t;

  // Count value held during the last permitted FPWAIT cycle.
  localparam logic [7:0] WAIT_LAST = 8'(FP_TIMEOUT - 1);

  state_t state_reg, state_next;

`ifdef MC_FP_EN
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       abort_reg, abort_next;
  logic       wait_expired;

  assign wait_expired = (wait_cnt_reg >= WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= 8'd0;
      abort_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      abort_reg    <= abort_next;
    end
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_reg == FPSTART)
      wait_cnt_next = 8'd0;
    else if (state_reg == FPWAIT && wait_cnt_reg != 8'hFF)
      wait_cnt_next = wait_cnt_reg + 8'd1;
  end

  // Timeout exit only when FpDone is low; the flag lives for the following FETCH.
  assign abort_next = (state_reg == FPWAIT) && !bus.FpDone && wait_expired;

  wire unused_ok = &{1'b0, bus.Funct[4:1]};
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_reg <= FETCH;
    else
      state_reg <= state_next;
  end

  wire unused_ok = &{1'b0, bus.FpDone, bus.Funct[4:1], WAIT_LAST};
`endif

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
`ifdef MC_FP_EN
          default: state_next = FPSTART;
`else
          default: state_next = FETCH;
`endif
        endcase
      end
      MEMADR:   state_next = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
`ifdef MC_FP_EN
      FPSTART:  state_next = FPWAIT;
      FPWAIT: begin
        if (bus.FpDone)
          state_next = FPWB;
        else if (wait_expired)
          state_next = FETCH;
        else
          state_next = FPWAIT;
      end
      FPWB:     state_next = FETCH;
`endif
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.FpStart   = 1'b0;
    bus.FpAbort   = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.State     = state_reg;
    case (state_reg)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.NextPC    = 1'b1;
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
`ifdef MC_FP_EN
        bus.FpAbort   = abort_reg;
`endif
      end
      DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      MEMADR: begin
        bus.ALUSrcB   = 2'b01;
      end
      MEMREAD: begin
        bus.AdrSrc    = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc    = 1'b1;
        bus.MemW      = 1'b1;
      end
      EXECUTER: begin
        bus.ALUOp     = 1'b1;
      end
      EXECUTEI: begin
        bus.ALUOp     = 1'b1;
        bus.ALUSrcB   = 2'b01;
      end
      ALUWB: begin
        bus.RegW      = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
      end
`ifdef MC_FP_EN
      FPSTART: begin
        bus.FpStart   = 1'b1;
      end
      FPWB: begin
        bus.RegW      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
